uart_frame_packer: RTL and testbench
====================================

# uart_frame_packer

Frame-aware byte packer between the UART byte receiver and the DDR3 write FIFO. Hunts a 2-byte start marker, packs the following bytes MSB-first into FIFO_WR_WIDTH-bit pixel words, and pulses the FIFO write enable once per word until exactly FRAME_WORDS words are written. It then reports frame completion. Optionally, it aborts a frame on a stalled serial link so the next frame starts word-aligned at WR_BEG_ADDR.

## Interface
- FIFO_WR_WIDTH, 32, output word width; must equal 8*FIFO_WR_BYTE
- FIFO_WR_BYTE, 4, bytes per word
- FRAME_WORDS, 307200, words per frame (640x480)
- TIMEOUT_CYC, 25000, idle cycles in DATA before abort (1 ms at 25 MHz)
- SYNC0 / SYNC1, 8'hA5 / 8'h5A, start-marker bytes

Ports:
- clk  in  1  single clock, same domain as the write FIFO write port; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- fifo_full  in  1  write FIFO full
- fifo_wr_data  out  FIFO_WR_WIDTH  packed word
- fifo_wr_en  out  1  one-cycle write strobe
- frame_done  out  1  one-cycle pulse, last word of frame issued
- frame_err  out  1  one-cycle pulse, frame aborted by timeout
- overflow  out  1  sticky, a word was dropped because fifo_full was high; cleared only by rst
- busy  out  1  high while state is not IDLE

## Operation
- States:
  - IDLE: rx_valid with SYNC0 -> SYNC; other bytes are ignored.
  - SYNC: SYNC1 -> DATA; SYNC0 -> stay in SYNC; any other byte -> IDLE.
  - DATA: packs payload bytes.
- Packing in DATA:
  - Each rx_valid shifts a byte in. The first byte of a word lands in [31:24] and the last in [7:0], so the R,G,B,pad order matches the read side's use of [31:8].
  - byte_cnt counts 0..FIFO_WR_BYTE-1. On the last byte, byte_cnt wraps to 0 and the word is issued.
- Word issue:
  - If fifo_full is low: fifo_wr_en=1 for one cycle, with fifo_wr_data holding the word.
  - If fifo_full is high: the word is dropped, fifo_wr_en stays 0, and overflow is set.
  - In both cases word_cnt increments, which keeps the frame length fixed.
- Frame end: the word issued at word_cnt==FRAME_WORDS-1 asserts frame_done in the same cycle as its fifo_wr_en. In that cycle word_cnt and byte_cnt clear and the state returns to IDLE.
- Bytes arriving in IDLE/SYNC never reach the FIFO.
- Timeout (macro enabled):
  - idle_cnt increments on each DATA cycle without rx_valid and clears on rx_valid.
  - When idle_cnt reaches TIMEOUT_CYC-1 with no rx_valid, the next cycle does all of the following: frame_err pulses, the partial word is discarded, byte_cnt, word_cnt and idle_cnt clear, and the state goes to IDLE.
  - If rx_valid arrives in the expiry cycle, the byte wins and no abort occurs.
- SYNC bytes appearing inside DATA are payload and are not re-interpreted.
- Reset values: fifo_wr_data=0, fifo_wr_en=0, frame_done=0, frame_err=0, overflow=0, busy=0, state IDLE, all counters 0.
- rst asserted mid-frame clears everything within the same edge. No partial word is emitted.

## Timing
- Latency: fifo_wr_en is asserted exactly 1 cycle after the rx_valid carrying the word's last byte. All outputs are registered.
- Throughput: one word per FIFO_WR_BYTE strobes. Back-to-back rx_valid every cycle is supported.
- word_cnt width is $clog2(FRAME_WORDS). idle_cnt width is $clog2(TIMEOUT_CYC).
- frame_done and frame_err are mutually exclusive in any cycle.

## Configuration
- Macro UART_PACK_TIMEOUT_EN.
- Defined: idle_cnt and the abort path are built as described.
- Undefined: no idle_cnt, DATA waits indefinitely, frame_err is tied to 0, and TIMEOUT_CYC is unused.

## Structure
- Package uart_pack_pkg holds:
  - the state enum (IDLE, SYNC, DATA)
  - SYNC0/SYNC1 default constants
  - the FRAME_WORDS default
- One sub-module, rx_idle_timer: counter with clear/enable inputs, producing a one-cycle expire output. Instantiated only under UART_PACK_TIMEOUT_EN.

## Test plan
- Marker A5 5A, then bytes 11 22 33 44 -> one fifo_wr_en 1 cycle after 44, fifo_wr_data=32'h11223344.
- FRAME_WORDS=4, marker + 16 bytes back-to-back -> 4 strobes, frame_done coincident with the 4th, busy falls, and further bytes are ignored until a new marker.
- Marker hunt: A5 A5 5A then 01 02 03 04 -> word 32'h01020304. The sequence A5 00 5A 01 02 03 04 -> no strobe.
- fifo_full held high during the 2nd word of a 4-word frame -> only 3 strobes, overflow=1 sticky, frame_done still after 16 payload bytes.
- UART_PACK_TIMEOUT_EN, TIMEOUT_CYC=8: marker + 2 bytes, then silence -> frame_err 8 cycles after last byte. A following marker + 4 bytes -> word aligned from byte 0.
- rst asserted after 3 payload bytes -> all outputs 0, IDLE. A new marker + 4 bytes -> single correct word, word_cnt restarted.

Source files
------------

// File: rtl/uart_pack_pkg.sv
// -----------------------------------------------------------------------------
// uart_pack_pkg
// Shared types and defaults for the UART frame packer.
//   state_t             : packer FSM states (IDLE, SYNC, DATA)
//   SYNC0_DEFAULT       : first start-marker byte
//   SYNC1_DEFAULT       : second start-marker byte
//   FRAME_WORDS_DEFAULT : words per frame (640x480 pixels)
//   cnt_width()         : counter width for a modulus, never below 1 bit
// -----------------------------------------------------------------------------
package uart_pack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] SYNC0_DEFAULT       = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT       = 8'h5A;
  localparam int         FRAME_WORDS_DEFAULT = 307200;

  // $clog2(1) is 0, which would produce a zero-width counter.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// -----------------------------------------------------------------------------
// rx_idle_timer
// Counts consecutive enabled cycles and flags the cycle in which the count
// has reached LIMIT-1 while still enabled. The counter restarts from zero on
// clear or on expiry.
// Ports:
//   clk    in  1  rising-edge clock
//   rst    in  1  synchronous, active-high reset
//   clear  in  1  restart the count (priority over en)
//   en     in  1  count this cycle
//   expire out 1  one-cycle, combinational: en high with count at LIMIT-1
// -----------------------------------------------------------------------------
module rx_idle_timer
  import uart_pack_pkg::*;
#(
  parameter int LIMIT = 25000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int            CW   = cnt_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] idle_cnt;

  // Combinational so the owner can register its abort in the same edge that
  // the count would otherwise step past LIMIT-1.
  assign expire = en && (idle_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || expire) begin
      idle_cnt <= '0;
    end else if (en) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_packer.sv
// -----------------------------------------------------------------------------
// uart_frame_packer
// Hunts the two-byte start marker in the UART byte stream, packs the following
// payload bytes MSB-first into FIFO_WR_WIDTH-bit words and writes exactly
// FRAME_WORDS words to the write FIFO, then pulses frame_done and resumes the
// marker hunt. Words issued while the FIFO is full are dropped, but still
// counted, so frame length stays fixed; the drop sets the sticky overflow flag.
//
// Optional feature, macro UART_PACK_TIMEOUT_EN:
//   defined   -> TIMEOUT_CYC silent cycles in DATA abort the frame (frame_err)
//   undefined -> DATA waits indefinitely; frame_err is constant 0
//
// Ports:
//   clk          in  1              rising-edge clock, FIFO write domain
//   rst          in  1              synchronous, active-high reset
//   rx_data      in  8              received UART byte
//   rx_valid     in  1              rx_data valid strobe
//   fifo_full    in  1              write FIFO full
//   fifo_wr_data out FIFO_WR_WIDTH  packed word
//   fifo_wr_en   out 1              one-cycle write strobe
//   frame_done   out 1              pulse with the last word of a frame
//   frame_err    out 1              pulse when a frame is aborted by timeout
//   overflow     out 1              sticky: a word was dropped on fifo_full
//   busy         out 1              state is not IDLE
// -----------------------------------------------------------------------------
module uart_frame_packer
  import uart_pack_pkg::*;
#(
  parameter int         FIFO_WR_WIDTH = 32,
  parameter int         FIFO_WR_BYTE  = 4,
  parameter int         FRAME_WORDS   = FRAME_WORDS_DEFAULT,
  parameter int         TIMEOUT_CYC   = 25000,
  parameter logic [7:0] SYNC0         = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1         = SYNC1_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     fifo_full,
  output logic [FIFO_WR_WIDTH-1:0] fifo_wr_data,
  output logic                     fifo_wr_en,
  output logic                     frame_done,
  output logic                     frame_err,
  output logic                     overflow,
  output logic                     busy
);

  localparam int             BCW       = cnt_width(FIFO_WR_BYTE);
  localparam int             WCW       = cnt_width(FRAME_WORDS);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FIFO_WR_BYTE - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

  state_t                   state_q;
  state_t                   state_d;
  logic [BCW-1:0]           byte_cnt;
  logic [WCW-1:0]           word_cnt;
  logic [FIFO_WR_WIDTH-1:0] shift_q;
  logic [FIFO_WR_WIDTH-1:0] word_next;
  logic                     take_byte;
  logic                     word_issue;
  logic                     frame_last;
  logic                     timeout_expire;

  // ---------------------------------------------------------------------------
  // Stalled-link abort
  // ---------------------------------------------------------------------------
`ifdef UART_PACK_TIMEOUT_EN
  logic timer_clear;
  logic timer_en;

  // Any byte restarts the silence count, so a byte landing in the expiry
  // cycle keeps the frame alive.
  assign timer_en    = (state_q == DATA) && !rx_valid;
  assign timer_clear = (state_q != DATA) || rx_valid;

  rx_idle_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .en     (timer_en),
    .expire (timeout_expire)
  );
`else
  logic unused_timeout_cfg;

  assign timeout_expire     = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    take_byte  = (state_q == DATA) && rx_valid;
    word_issue = take_byte && (byte_cnt == LAST_BYTE);
    frame_last = word_issue && (word_cnt == LAST_WORD);
    // Earlier bytes move toward the MSB, so the first byte of a word ends up
    // in the top byte lane once the word is complete.
    word_next  = (shift_q << 8) | FIFO_WR_WIDTH'(rx_data);

    unique case (state_q)
      IDLE: begin
        if (rx_valid && (rx_data == SYNC0)) state_d = SYNC;
      end
      SYNC: begin
        // A repeated SYNC0 may itself be the start of the real marker.
        if (rx_valid) begin
          if (rx_data == SYNC1)      state_d = DATA;
          else if (rx_data != SYNC0) state_d = IDLE;
        end
      end
      DATA: begin
        // frame_last needs rx_valid and the timeout needs its absence, so
        // frame_done and frame_err can never fire together.
        if (frame_last || timeout_expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_cnt     <= '0;
      word_cnt     <= '0;
      // NOTE: the byte shifter is cleared too, so a reset mid-word cannot leak
      // stale payload into the first word of the next frame.
      shift_q      <= '0;
      fifo_wr_data <= '0;
      fifo_wr_en   <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      fifo_wr_en <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= timeout_expire;

      if (take_byte) begin
        shift_q  <= word_next;
        byte_cnt <= word_issue ? '0 : byte_cnt + 1'b1;

        if (word_issue) begin
          // Dropped words still advance word_cnt to keep the frame length.
          word_cnt   <= frame_last ? '0 : word_cnt + 1'b1;
          frame_done <= frame_last;
          if (fifo_full) begin
            overflow <= 1'b1;
          end else begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= word_next;
          end
        end
      end else if (timeout_expire) begin
        // Discard the partial word so the next frame starts word-aligned.
        shift_q  <= '0;
        byte_cnt <= '0;
        word_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_packer
// Self-checking bench for uart_frame_packer (FRAME_WORDS=4, TIMEOUT_CYC=8).
// Stimulus byte streams are scanned by a stream-level reference model (find
// the marker pair, slice the following payload into words) and the words
// captured from the FIFO write port are compared against it.
// Build with +define+UART_PACK_TIMEOUT_EN to exercise the abort path.
// -----------------------------------------------------------------------------
module tb_uart_frame_packer;

  localparam int         W  = 32;
  localparam int         NB = 4;
  localparam int         FW = 4;
  localparam int         TO = 8;
  localparam logic [7:0] S0 = 8'hA5;
  localparam logic [7:0] S1 = 8'h5A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = '0;
  logic         rx_valid = 1'b0;
  logic         fifo_full = 1'b0;
  logic [W-1:0] fifo_wr_data;
  logic         fifo_wr_en;
  logic         frame_done;
  logic         frame_err;
  logic         overflow;
  logic         busy;

  always #5 clk = ~clk;

  uart_frame_packer #(
    .FIFO_WR_WIDTH (W),
    .FIFO_WR_BYTE  (NB),
    .FRAME_WORDS   (FW),
    .TIMEOUT_CYC   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .fifo_full    (fifo_full),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .busy         (busy)
  );

  int errors = 0;
  int checks = 0;

  // ---------------------------------------------------------------------------
  // Write-port monitor (samples 1 time unit after each rising edge)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] data;
    logic         done;
    logic         busy;
  } wr_t;

  wr_t got_q[$];
  int  done_cnt  = 0;
  int  err_cnt   = 0;
  int  excl_viol = 0;

  always begin
    @(posedge clk);
    #1;
    if (fifo_wr_en === 1'b1) got_q.push_back({fifo_wr_data, frame_done, busy});
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (frame_done === 1'b1 && frame_err === 1'b1) excl_viol++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  logic [7:0] stim_b[$];
  bit         stim_full[$];
  int         stim_gap[$];

  logic [W-1:0] exp_data[$];
  bit           exp_last[$];
  int           exp_done;
  bit           exp_ovf;

  // One clock cycle: inputs applied at the falling edge, outputs of the
  // following rising edge are visible when the task returns.
  task automatic step(input logic v, input logic [7:0] d, input logic f);
    rx_valid  = v;
    rx_data   = d;
    fifo_full = f;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    excl_viol = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic new_stream();
    stim_b.delete();
    stim_full.delete();
    stim_gap.delete();
  endtask

  task automatic add(input logic [7:0] b, input bit f, input int g);
    stim_b.push_back(b);
    stim_full.push_back(f);
    stim_gap.push_back(g);
  endtask

  task automatic run_stream();
    for (int k = 0; k < stim_b.size(); k++) begin
      step(1'b1, stim_b[k], stim_full[k]);
      idle(stim_gap[k]);
    end
    idle(4);
  endtask

  // Reference model: scan for the first adjacent marker pair, slice the next
  // FW*NB bytes into big-endian words, then hunt again. A frame cut short by
  // the end of the stream produces only its complete words and ends the scan.
  task automatic model_expect();
    int           i;
    int           p;
    int           n;
    bit           stop;
    logic [W-1:0] word;
    exp_data.delete();
    exp_last.delete();
    exp_done = 0;
    exp_ovf  = 0;
    n    = stim_b.size();
    i    = 0;
    stop = 0;
    while (i < n && !stop) begin
      if (i + 1 < n && stim_b[i] == S0 && stim_b[i+1] == S1) begin
        p = i + 2;
        for (int w = 0; w < FW; w++) begin
          if (p + NB > n) begin
            stop = 1;
            break;
          end
          word = '0;
          for (int j = 0; j < NB; j++) word = (word << 8) | W'(stim_b[p+j]);
          if (stim_full[p+NB-1]) exp_ovf = 1;
          else begin
            exp_data.push_back(word);
            exp_last.push_back(w == FW - 1);
          end
          if (w == FW - 1) exp_done++;
          p += NB;
        end
        if (p + NB > n && p < n && !stop) i = p;
        else i = p;
        if (stop) i = n;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_stream(input string name);
    checks++;
    if (got_q.size() != exp_data.size()) begin
      errors++;
      $display("FAIL %s word_count: got %0d expected %0d", name, got_q.size(), exp_data.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_data.size(); i++) begin
      checks++;
      if (got_q[i].data !== exp_data[i]) begin
        errors++;
        $display("FAIL %s word[%0d]: got %08h expected %08h", name, i, got_q[i].data, exp_data[i]);
      end
      checks++;
      if (got_q[i].done !== exp_last[i]) begin
        errors++;
        $display("FAIL %s done_flag[%0d]: got %0b expected %0b", name, i, got_q[i].done, exp_last[i]);
      end
    end
    checks++;
    if (done_cnt != exp_done) begin
      errors++;
      $display("FAIL %s frame_done_count: got %0d expected %0d", name, done_cnt, exp_done);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s overflow: got %0b expected %0b", name, overflow, exp_ovf);
    end
    checks++;
    if (err_cnt != 0) begin
      errors++;
      $display("FAIL %s frame_err_count: got %0d expected 0", name, err_cnt);
    end
    checks++;
    if (excl_viol != 0) begin
      errors++;
      $display("FAIL %s done_err_overlap: got %0d expected 0", name, excl_viol);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, S0, 1'b1);
    step(1'b1, S1, 1'b1);
    checks++;
    if (fifo_wr_data !== '0) begin errors++; $display("FAIL reset fifo_wr_data: got %08h expected 0", fifo_wr_data); end
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset fifo_wr_en: got %0b expected 0", fifo_wr_en); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %0b expected 0", frame_done); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset frame_err: got %0b expected 0", frame_err); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %0b expected 0", overflow); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %0b expected 0", busy); end
    do_reset();
  endtask

  task automatic test_single_word();
    do_reset();
    step(1'b1, S0, 1'b0);
    step(1'b1, S1, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single busy_after_marker: got %0b expected 1", busy); end
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single early_strobe: got %0b expected 0", fifo_wr_en); end
    step(1'b1, 8'h44, 1'b0);
    checks++;
    if (fifo_wr_en !== 1'b1) begin errors++; $display("FAIL single strobe_latency: got %0b expected 1", fifo_wr_en); end
    checks++;
    if (fifo_wr_data !== 32'h11223344) begin errors++; $display("FAIL single word: got %08h expected 11223344", fifo_wr_data); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL single frame_done: got %0b expected 0", frame_done); end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL single strobe_width: got %0b expected 0", fifo_wr_en); end
  endtask

  task automatic test_full_frame();
    logic [7:0] b;
    do_reset();
    new_stream();
    add(S0, 0, 0);
    add(S1, 0, 0);
    for (int i = 0; i < FW * NB; i++) add(8'($urandom), 0, 0);
    // Trailing bytes with no marker must be ignored once the frame is done.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      if (b == S0) b = 8'h00;
      add(b, 0, 0);
    end
    model_expect();
    run_stream();
    check_stream("full_frame");
    checks++;
    if (got_q.size() != FW) begin errors++; $display("FAIL full_frame strobes: got %0d expected %0d", got_q.size(), FW); end
    if (got_q.size() == FW) begin
      checks++;
      if (got_q[FW-1].busy !== 1'b0) begin errors++; $display("FAIL full_frame busy_at_done: got %0b expected 0", got_q[FW-1].busy); end
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL full_frame busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_marker_hunt();
    logic [7:0] seq_a[7] = '{8'hA5, 8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0] seq_b[7] = '{8'hA5, 8'h00, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    foreach (seq_a[i]) step(1'b1, seq_a[i], 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL hunt_repeat strobes: got %0d expected 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0].data !== 32'h01020304) begin errors++; $display("FAIL hunt_repeat word: got %08h expected 01020304", got_q[0].data); end
    end
    do_reset();
    foreach (seq_b[i]) step(1'b1, seq_b[i], 1'b0);
    idle(3);
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL hunt_broken strobes: got %0d expected 0", got_q.size()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL hunt_broken busy: got %0b expected 0", busy); end
  endtask

  task automatic test_overflow();
    do_reset();
    new_stream();
    add(S0, 0, 0);
    add(S1, 0, 0);
    for (int i = 0; i < FW * NB; i++) add(8'($urandom), (i >= NB && i < 2 * NB), 0);
    model_expect();
    run_stream();
    check_stream("overflow");
    checks++;
    if (got_q.size() != FW - 1) begin errors++; $display("FAIL overflow strobes: got %0d expected %0d", got_q.size(), FW - 1); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL overflow frame_done: got %0d expected 1", done_cnt); end
    // A clean second frame must not clear the sticky flag.
    clear_mon();
    new_stream();
    add(S0, 0, 0);
    add(S1, 0, 0);
    for (int i = 0; i < FW * NB; i++) add(8'($urandom), 0, 1);
    run_stream();
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow sticky: got %0b expected 1", overflow); end
    checks++;
    if (got_q.size() != FW) begin errors++; $display("FAIL overflow second_frame: got %0d expected %0d", got_q.size(), FW); end
    do_reset();
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow reset_clear: got %0b expected 0", overflow); end
  endtask

`ifdef UART_PACK_TIMEOUT_EN
  task automatic test_timeout();
    int k_err;
    do_reset();
    step(1'b1, S0, 1'b0);
    step(1'b1, S1, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    k_err = -1;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 8'h00, 1'b0);
      if (frame_err === 1'b1) begin
        k_err = k;
        break;
      end
    end
    checks++;
    if (k_err != TO) begin errors++; $display("FAIL timeout latency: got %0d expected %0d", k_err, TO); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout busy: got %0b expected 0", busy); end
    idle(2);
    checks++;
    if (err_cnt != 1) begin errors++; $display("FAIL timeout err_pulses: got %0d expected 1", err_cnt); end
    checks++;
    if (got_q.size() != 0) begin errors++; $display("FAIL timeout partial_word: got %0d expected 0", got_q.size()); end
    // Next frame must start at byte 0 of a fresh word.
    clear_mon();
    new_stream();
    add(S0, 0, 0);
    add(S1, 0, 0);
    add(8'h11, 0, 0);
    add(8'h22, 0, 0);
    add(8'h33, 0, 0);
    add(8'h44, 0, 0);
    model_expect();
    run_stream();
    check_stream("timeout_realign");
    // A byte arriving exactly in the expiry cycle keeps the frame alive.
    do_reset();
    step(1'b1, S0, 1'b0);
    step(1'b1, S1, 1'b0);
    step(1'b1, 8'hD1, 1'b0);
    idle(TO - 1);
    step(1'b1, 8'hD2, 1'b0);
    step(1'b1, 8'hD3, 1'b0);
    step(1'b1, 8'hD4, 1'b0);
    idle(2);
    checks++;
    if (err_cnt != 0) begin errors++; $display("FAIL timeout byte_wins err: got %0d expected 0", err_cnt); end
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL timeout byte_wins strobes: got %0d expected 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0].data !== 32'hD1D2D3D4) begin errors++; $display("FAIL timeout byte_wins word: got %08h expected d1d2d3d4", got_q[0].data); end
    end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    step(1'b1, S0, 1'b0);
    step(1'b1, S1, 1'b0);
    step(1'b1, 8'hC1, 1'b0);
    step(1'b1, 8'hC2, 1'b0);
    idle(5 * TO);
    checks++;
    if (err_cnt != 0) begin errors++; $display("FAIL no_timeout err_pulses: got %0d expected 0", err_cnt); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL no_timeout busy: got %0b expected 1", busy); end
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hC4, 1'b0);
    idle(2);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL no_timeout strobes: got %0d expected 1", got_q.size()); end
    else begin
      checks++;
      if (got_q[0].data !== 32'hC1C2C3C4) begin errors++; $display("FAIL no_timeout word: got %08h expected c1c2c3c4", got_q[0].data); end
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    do_reset();
    step(1'b1, S0, 1'b0);
    step(1'b1, S1, 1'b0);
    for (int i = 0; i < NB + 3; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    checks++;
    if (got_q.size() != 1) begin errors++; $display("FAIL midreset first_word: got %0d expected 1", got_q.size()); end
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if ({fifo_wr_data, fifo_wr_en, frame_done, frame_err, overflow, busy} !== '0) begin
      errors++;
      $display("FAIL midreset outputs: got data=%08h en=%0b done=%0b err=%0b ovf=%0b busy=%0b expected all 0",
               fifo_wr_data, fifo_wr_en, frame_done, frame_err, overflow, busy);
    end
    rst = 1'b0;
    idle(2);
    clear_mon();
    // A full frame afterwards shows word_cnt restarted from zero.
    new_stream();
    add(S0, 0, 0);
    add(S1, 0, 0);
    for (int i = 0; i < FW * NB; i++) add(8'($urandom), 0, 0);
    model_expect();
    run_stream();
    check_stream("midreset_frame");
  endtask

  task automatic test_random_frames();
    for (int it = 0; it < 8; it++) begin
      do_reset();
      new_stream();
      for (int i = 0; i < int'($urandom_range(5, 0)); i++) add(8'($urandom), 0, $urandom_range(2, 0));
      add(S0, 0, $urandom_range(3, 0));
      add(S1, 0, $urandom_range(3, 0));
      for (int i = 0; i < FW * NB; i++) add(8'($urandom), ($urandom_range(7, 0) == 0), $urandom_range(3, 0));
      for (int i = 0; i < int'($urandom_range(6, 0)); i++) add(8'($urandom), 0, $urandom_range(1, 0));
      model_expect();
      run_stream();
      check_stream($sformatf("random_%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_frame();
    test_marker_hunt();
    test_overflow();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
